str2mm_trg: RTL and testbench
=============================

# str2mm_trg

Triggered stream-capture buffer: the parametrised successor to `str2mm`. It accepts an AXI4-stream of DN signed samples per beat into a circular RAM of DL beats, arms under software control and stops a programmable number of beats after a hardware or software trigger. The block sits between an acquisition stream (ADC path) and the system bus. Software reads control and status registers and the captured samples, one sign-extended sample per 32-bit word.

## Interface
- DN, 1: samples per stream beat; power of 2.
- DW, 14: sample width in bits, signed; DW ≤ 32.
- DL, 256: buffer depth in beats; power of 2. AW = $clog2(DL).
- CW, 32: post-trigger counter width.
- clk  in  1  clock; stream and bus share it.
- rstn  in  1  reset, asynchronous, active-low.
- str_dat  in  DN*DW  stream data; lane n is bits [n*DW +: DW].
- str_vld  in  1  stream valid.
- str_rdy  out  1  stream ready.
- trg  in  1  hardware trigger, level sampled each cycle.
- bus_addr  in  32  byte address.
- bus_wdata  in  32  write data.
- bus_wen  in  1  write strobe, single cycle.
- bus_ren  in  1  read strobe, single cycle.
- bus_rdata  out  32  read data.
- bus_ack  out  1  access acknowledge.
- bus_err  out  1  access error.

## Operation
- Register map, selected when bus_addr[AW+$clog2(DN)+2] = 0:
  - 0x00 CTL. W bit0 = arm, bit1 = abort, bit2 = software trigger. R bits[1:0] = state.
  - 0x04 STS, read-only. bit0 = triggered, bit1 = done, bit2 = wrapped (write pointer has passed DL-1 since arm).
  - 0x08 POST, R/W, CW bits: number of beats stored from the trigger cycle onward.
  - 0x0C TPTR, read-only: beat address of the write pointer in the trigger cycle.
  - 0x10 WPTR, read-only: current write pointer.
- Buffer region, selected when that bit = 1:
  - Word index i = bus_addr[AW+$clog2(DN)+1:2].
  - Beat = i / DN, lane = i % DN.
  - Returned value is the sample sign-extended to 32 bits.
  - Buffer writes are ignored but still acked.
- Any other register offset: ack with err = 1, rdata = 0.
- FSM states: IDLE = 0, ARMED = 1, TRIG = 2, DONE = 3.
  - Arm in any state: WPTR = 0, cnt = 0, STS cleared, go to ARMED. Arm takes priority over abort written in the same word.
  - Abort: go to IDLE. Buffer contents and pointers are kept.
  - ARMED: each accepted beat (vld & rdy) is written at WPTR, then WPTR++. WPTR wraps DL-1 → 0 and sets wrapped.
  - Trigger event = trg | software trigger, recognised only in ARMED. It is ignored in IDLE, TRIG and DONE.
  - Trigger cycle in ARMED:
    - TPTR = WPTR (value before increment); triggered = 1.
    - If POST = 0: go to DONE, and the beat in that cycle is not written.
    - Otherwise the beat (if present) is written, cnt = vld ? 1 : 0, and the next state is TRIG, or DONE if cnt reaches POST.
  - TRIG: write accepted beats and increment cnt. When cnt reaches POST, go to DONE and set done = 1.
  - IDLE and DONE: beats are accepted and discarded.
- str_rdy = 1 whenever out of reset. The block never back-pressures.
- POST ≥ DL is legal: the buffer overwrites past TPTR and wrapped is set.

## Timing
- Reset values:
  - str_rdy = 0, bus_ack = 0, bus_err = 0, bus_rdata = 0.
  - State = IDLE; WPTR, TPTR, POST and cnt = 0; STS = 0.
  - RAM contents are undefined.
- str_rdy rises on the first clk edge after rstn deasserts.
- Bus access: ack (and err, rdata) is registered and valid exactly 1 cycle after wen or ren, for 1 cycle only. Back-to-back accesses are allowed every cycle.
- A CTL write takes effect in the ack cycle. A beat in that same cycle is handled under the new state.
- RAM has 1 read port and 1 write port. Reading beat b in the cycle b is written returns the old data.
- Trigger to done: DONE is entered on the clock edge at which the POST-th beat counting from the trigger cycle is accepted. STS reflects it on a read issued the following cycle.
- Asserting rstn mid-capture returns the block to IDLE at once. RAM is not cleared.

## Test plan
- Reset check: hold rstn low 4 cycles, then read 0x00–0x10 → all 0, err = 0, ack 1 cycle after ren. str_rdy = 0 during reset and 1 afterwards.
- Basic capture (DN=1, DL=256): set POST = 8, arm, stream ramp -8..7 continuously, pulse trg with sample -4. Expect STS = triggered|done, TPTR = 4, WPTR = 12. Buffer words 0..11 = -8..3 sign-extended (0xFFFFFFF8…); word 12 is not overwritten.
- Wrap: set POST = 4, arm, stream 300 beats of value i%256, software trigger at beat 290. Expect wrapped = 1, TPTR = 34, WPTR = 38, buffer word 37 = 293%256 = 37.
- POST = 0 with trg in the same cycle as beat 5: DONE, TPTR = 5, WPTR = 5, beat 5 not written.
- Abort and priority: abort mid-TRIG → state 0 and subsequent beats are not stored. Write CTL = 0x3 → state ARMED. trg in IDLE → triggered stays 0.
- DN=2, DW=14: beat {lane1 = 0x1FFF, lane0 = 0x2000} at beat 0 → word 0 = 0xFFFFE000, word 1 = 0x00001FFF. A read of unmapped offset 0x14 → err = 1.

Source files
------------

// File: rtl/str2mm_trg.sv
// Triggered stream-capture buffer: circular RAM of DL beats (DN samples each)
// fed from a stream. It arms from software and stops POST beats after a
// hardware or software trigger. Registers and the sign-extended captured
// samples are readable over a simple single-cycle strobe bus.
//
// Handshake: a stream beat transfers on every cycle where str_vld and str_rdy
// are both high. str_rdy is held high whenever out of reset, so every valid
// beat transfers. Bus: one wen or ren strobe per access. ack/err/rdata appear
// registered exactly one cycle later, for one cycle. Strobes may repeat every
// cycle.
module str2mm_trg #(
  parameter int DN = 1,
  parameter int DW = 14,
  parameter int DL = 256,
  parameter int CW = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DN*DW-1:0]     str_dat,
  input  logic                 str_vld,
  output logic                 str_rdy,
  input  logic                 trg,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  input  logic                 bus_wen,
  input  logic                 bus_ren,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ack,
  output logic                 bus_err,
  output logic [1:0]           dbg_state
);
  localparam int AW = $clog2(DL);
  localparam int LW = $clog2(DN);
  localparam int IW = AW + LW;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIG = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     wptr, tptr;
  logic [CW-1:0]     post, cnt, cnt_nxt;
  logic              sts_trg, sts_done, sts_wrap, sw_trg;
  logic [DN*DW-1:0]  mem [DL];

  logic              acc, trig_ev, wr, set_tptr, set_done;
  logic              buf_sel, ctl_wr, post_wr, arm, abort;
  logic [31:0]       off, shift, rd_val;
  logic [IW-1:0]     widx;
  logic [AW-1:0]     rbeat;
  logic [DW-1:0]     rsample;
  logic              rd_err;
  logic              unused;

  assign unused    = ^bus_addr[31:IW+3];
  assign dbg_state = state;

  // Address decode, register/buffer read mux and control-write strobes.
  always_comb begin
    buf_sel = bus_addr[IW+2];
    off     = 32'(bus_addr[IW+1:0]);
    widx    = bus_addr[IW+1:2];
    rbeat   = widx[IW-1:LW];
    shift   = (32'(widx) % 32'(DN)) * 32'(DW);
    rsample = DW'(mem[rbeat] >> shift);
    rd_val  = '0;
    rd_err  = 1'b0;
    if (buf_sel) begin
      rd_val = 32'($signed(rsample));
    end else begin
      case (off)
        32'h00:  rd_val = {30'd0, state};
        32'h04:  rd_val = {29'd0, sts_wrap, sts_done, sts_trg};
        32'h08:  rd_val = 32'(post);
        32'h0C:  rd_val = 32'(tptr);
        32'h10:  rd_val = 32'(wptr);
        default: rd_err = 1'b1;
      endcase
    end
    ctl_wr  = bus_wen && !buf_sel && (off == 32'h00);
    post_wr = bus_wen && !buf_sel && (off == 32'h08);
    arm     = ctl_wr && bus_wdata[0];
    abort   = ctl_wr && bus_wdata[1];
  end

  // Capture FSM next state, RAM write enable and trigger bookkeeping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr        = 1'b0;
    set_tptr  = 1'b0;
    set_done  = 1'b0;
    acc       = str_vld && str_rdy;
    trig_ev   = trg || sw_trg;
    case (state)
      ARMED: begin
        if (trig_ev) begin
          set_tptr = 1'b1;
          if (post == '0) begin
            state_nxt = DONE;
            set_done  = 1'b1;
          end else begin
            wr      = acc;
            cnt_nxt = acc ? CW'(1) : '0;
            if (cnt_nxt == post) begin
              state_nxt = DONE;
              set_done  = 1'b1;
            end else begin
              state_nxt = TRIG;
            end
          end
        end else begin
          wr = acc;
        end
      end
      TRIG: begin
        if (acc) begin
          wr      = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == post) begin
            state_nxt = DONE;
            set_done  = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // A control write overrides the stream-driven transition; arm wins over abort.
    if (arm) state_nxt = ARMED;
    else if (abort) state_nxt = IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pointers, post-trigger counter, status flags and stream ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      str_rdy  <= 1'b0;
      sw_trg   <= 1'b0;
      post     <= '0;
      cnt      <= '0;
      wptr     <= '0;
      tptr     <= '0;
      sts_trg  <= 1'b0;
      sts_done <= 1'b0;
      sts_wrap <= 1'b0;
    end else begin
      str_rdy <= 1'b1;
      sw_trg  <= ctl_wr && bus_wdata[2];
      if (post_wr) post <= CW'(bus_wdata);
      if (arm) begin
        wptr     <= '0;
        cnt      <= '0;
        sts_trg  <= 1'b0;
        sts_done <= 1'b0;
        sts_wrap <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        if (wr) begin
          wptr <= wptr + AW'(1);
          if (wptr == AW'(DL - 1)) sts_wrap <= 1'b1;
        end
        if (set_tptr) begin
          tptr    <= wptr;
          sts_trg <= 1'b1;
        end
        if (set_done) sts_done <= 1'b1;
      end
    end
  end

  // Sample RAM write port; contents survive reset and abort.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= str_dat;
  end

  // Registered bus response, one cycle after each strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= bus_wen || bus_ren;
      bus_err   <= (bus_wen || bus_ren) && rd_err;
      bus_rdata <= bus_ren ? rd_val : 32'd0;
    end
  end
endmodule

// File: tb/tb_str2mm_trg.sv
// Directed bench for str2mm_trg: one DN=1/DL=256 instance and one DN=2/DL=16
// instance sharing clock and reset.
module tb_str2mm_trg;
  localparam logic [31:0] BUF1 = 32'h400;
  localparam logic [31:0] BUF2 = 32'h080;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [13:0] str_dat;
  logic        str_vld, str_rdy, trg;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_wen, bus_ren, bus_ack, bus_err;
  logic [1:0]  dbg_state;

  logic [27:0] str_dat2;
  logic        str_vld2, str_rdy2, trg2;
  logic [31:0] bus_addr2, bus_wdata2, bus_rdata2;
  logic        bus_wen2, bus_ren2, bus_ack2, bus_err2;
  logic [1:0]  dbg_state2;

  int n_checks = 0;
  int n_fail   = 0;

  str2mm_trg #(.DN(1), .DW(14), .DL(256), .CW(32)) u_dut (
    .clk(clk), .rstn(rstn), .str_dat(str_dat), .str_vld(str_vld), .str_rdy(str_rdy),
    .trg(trg), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen),
    .bus_ren(bus_ren), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  str2mm_trg #(.DN(2), .DW(14), .DL(16), .CW(32)) u_dut2 (
    .clk(clk), .rstn(rstn), .str_dat(str_dat2), .str_vld(str_vld2), .str_rdy(str_rdy2),
    .trg(trg2), .bus_addr(bus_addr2), .bus_wdata(bus_wdata2), .bus_wen(bus_wen2),
    .bus_ren(bus_ren2), .bus_rdata(bus_rdata2), .bus_ack(bus_ack2), .bus_err(bus_err2),
    .dbg_state(dbg_state2)
  );

  // Driver tasks: start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    @(posedge clk); #1;
    bus_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic e, output logic k);
    bus_addr = a; bus_ren = 1'b1;
    @(posedge clk); #1;
    bus_ren = 1'b0;
    d = bus_rdata; e = bus_err; k = bus_ack;
  endtask

  task automatic beat(input logic [13:0] d, input logic t);
    str_dat = d; str_vld = 1'b1; trg = t;
    @(posedge clk); #1;
    str_vld = 1'b0; trg = 1'b0; bus_wen = 1'b0; bus_ren = 1'b0;
  endtask

  task automatic bus_write2(input logic [31:0] a, input logic [31:0] d);
    bus_addr2 = a; bus_wdata2 = d; bus_wen2 = 1'b1;
    @(posedge clk); #1;
    bus_wen2 = 1'b0;
  endtask

  task automatic bus_read2(input logic [31:0] a, output logic [31:0] d, output logic e, output logic k);
    bus_addr2 = a; bus_ren2 = 1'b1;
    @(posedge clk); #1;
    bus_ren2 = 1'b0;
    d = bus_rdata2; e = bus_err2; k = bus_ack2;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e, k;
    rstn = 1'b0;
    str_dat = '0; str_vld = 1'b0; trg = 1'b0;
    bus_addr = '0; bus_wdata = '0; bus_wen = 1'b0; bus_ren = 1'b0;
    str_dat2 = '0; str_vld2 = 1'b0; trg2 = 1'b0;
    bus_addr2 = '0; bus_wdata2 = '0; bus_wen2 = 1'b0; bus_ren2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (str_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_low got=%b exp=0", str_rdy); end
    n_checks++; if (str_rdy2 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy2_low got=%b exp=0", str_rdy2); end
    n_checks++; if (bus_ack !== 1'b0 || bus_err !== 1'b0 || bus_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_bus got ack=%b err=%b rdata=%h exp 0/0/0", bus_ack, bus_err, bus_rdata);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (str_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_high got=%b exp=1", str_rdy); end
    n_checks++; if (str_rdy2 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy2_high got=%b exp=1", str_rdy2); end
    // Back-to-back reads of every register.
    for (int i = 0; i < 5; i++) begin
      bus_read(32'(i * 4), d, e, k);
      n_checks++; if (k !== 1'b1) begin n_fail++; $display("FAIL reset_ack[%0d] got=%b exp=1", i, k); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d] got=%b exp=0", i, e); end
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg[%0d] got=%h exp=0", i, d); end
    end
    @(posedge clk); #1;
    n_checks++; if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle got=%b exp=0", bus_ack); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic e, k;
    // Prefill words 0..15 with 0x55, then abort.
    bus_write(32'h00, 32'h1);
    for (int i = 0; i < 16; i++) beat(14'h55, 1'b0);
    bus_write(32'h00, 32'h2);
    bus_write(32'h08, 32'd8);
    bus_write(32'h00, 32'h1);
    for (int i = 0; i < 16; i++) beat(14'(i - 8), (i == 4));
    bus_read(32'h00, d, e, k);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL basic_state got=%h exp=3", d); end
    bus_read(32'h04, d, e, k);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL basic_sts got=%h exp=3", d); end
    bus_read(32'h0C, d, e, k);
    n_checks++; if (d !== 32'd4) begin n_fail++; $display("FAIL basic_tptr got=%h exp=4", d); end
    bus_read(32'h10, d, e, k);
    n_checks++; if (d !== 32'd12) begin n_fail++; $display("FAIL basic_wptr got=%h exp=12", d); end
    for (int i = 0; i < 12; i++) begin
      bus_read(BUF1 + 32'(i * 4), d, e, k);
      n_checks++; if (d !== 32'(i - 8)) begin n_fail++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, d, 32'(i - 8)); end
    end
    bus_read(BUF1 + 32'd48, d, e, k);
    n_checks++; if (d !== 32'h55) begin n_fail++; $display("FAIL basic_word12_kept got=%h exp=55", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic e, k;
    bus_write(32'h08, 32'd4);
    bus_write(32'h00, 32'h1);
    for (int i = 0; i < 300; i++) begin
      // Software trigger written one cycle ahead so it acts on beat 290.
      if (i == 289) begin bus_addr = 32'h00; bus_wdata = 32'h4; bus_wen = 1'b1; end
      beat(14'(i % 256), 1'b0);
    end
    bus_read(32'h04, d, e, k);
    n_checks++; if (d !== 32'd7) begin n_fail++; $display("FAIL wrap_sts got=%h exp=7", d); end
    bus_read(32'h0C, d, e, k);
    n_checks++; if (d !== 32'd34) begin n_fail++; $display("FAIL wrap_tptr got=%0d exp=34", d); end
    bus_read(32'h10, d, e, k);
    n_checks++; if (d !== 32'd38) begin n_fail++; $display("FAIL wrap_wptr got=%0d exp=38", d); end
    bus_read(BUF1 + 32'd148, d, e, k);
    n_checks++; if (d !== 32'd37) begin n_fail++; $display("FAIL wrap_word37 got=%h exp=25", d); end
    bus_read(BUF1 + 32'd136, d, e, k);
    n_checks++; if (d !== 32'd34) begin n_fail++; $display("FAIL wrap_word34 got=%h exp=22", d); end
  endtask

  task automatic test_post0();
    logic [31:0] d; logic e, k;
    bus_write(32'h08, 32'd0);
    bus_write(32'h00, 32'h1);
    for (int i = 0; i < 7; i++) beat(14'(100 + i), (i == 5));
    bus_read(32'h00, d, e, k);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL post0_state got=%h exp=3", d); end
    bus_read(32'h04, d, e, k);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL post0_sts got=%h exp=3", d); end
    bus_read(32'h0C, d, e, k);
    n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL post0_tptr got=%0d exp=5", d); end
    bus_read(32'h10, d, e, k);
    n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL post0_wptr got=%0d exp=5", d); end
    bus_read(BUF1 + 32'd16, d, e, k);
    n_checks++; if (d !== 32'd104) begin n_fail++; $display("FAIL post0_word4 got=%0d exp=104", d); end
    bus_read(BUF1 + 32'd20, d, e, k);
    n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL post0_word5_kept got=%0d exp=5", d); end
    bus_read(BUF1 + 32'd24, d, e, k);
    n_checks++; if (d !== 32'd6) begin n_fail++; $display("FAIL post0_word6_kept got=%0d exp=6", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d; logic e, k;
    bus_write(32'h08, 32'd10);
    bus_write(32'h00, 32'h1);
    beat(14'd200, 1'b0); beat(14'd201, 1'b1); beat(14'd202, 1'b0);
    bus_read(32'h00, d, e, k);
    n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL abort_trig_state got=%h exp=2", d); end
    bus_write(32'h00, 32'h2);
    for (int i = 0; i < 3; i++) beat(14'h1AA, 1'b0);
    bus_read(32'h00, d, e, k);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL abort_state got=%h exp=0", d); end
    bus_read(32'h10, d, e, k);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL abort_wptr got=%0d exp=3", d); end
    bus_read(BUF1 + 32'd4, d, e, k);
    n_checks++; if (d !== 32'd201) begin n_fail++; $display("FAIL abort_word1 got=%0d exp=201", d); end
    bus_read(BUF1 + 32'd12, d, e, k);
    n_checks++; if (d !== 32'd103) begin n_fail++; $display("FAIL abort_word3_kept got=%0d exp=103", d); end
    bus_write(32'h00, 32'h3);
    bus_read(32'h00, d, e, k);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL arm_priority_state got=%h exp=1", d); end
    bus_read(32'h04, d, e, k);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL arm_sts_clear got=%h exp=0", d); end
    bus_read(32'h10, d, e, k);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL arm_wptr_clear got=%0d exp=0", d); end
    bus_write(32'h00, 32'h2);
    beat(14'h10, 1'b1);
    bus_read(32'h04, d, e, k);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL idle_trg_ignored got=%h exp=0", d); end
  endtask

  task automatic test_bus_err();
    logic [31:0] d; logic e, k;
    bus_read(32'h14, d, e, k);
    n_checks++; if (k !== 1'b1 || e !== 1'b1 || d !== 32'd0) begin
      n_fail++; $display("FAIL unmapped_read got ack=%b err=%b rdata=%h exp 1/1/0", k, e, d);
    end
    bus_write(BUF1, 32'h123);
    n_checks++; if (bus_ack !== 1'b1 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL buf_write_ack got ack=%b err=%b exp 1/0", bus_ack, bus_err);
    end
    bus_read(BUF1, d, e, k);
    n_checks++; if (d !== 32'd200) begin n_fail++; $display("FAIL buf_write_ignored got=%0d exp=200", d); end
  endtask

  task automatic test_dn2();
    logic [31:0] d; logic e, k;
    bus_write2(32'h00, 32'h1);
    str_dat2 = {14'h1FFF, 14'h2000}; str_vld2 = 1'b1;
    @(posedge clk); #1;
    str_vld2 = 1'b0;
    bus_read2(BUF2, d, e, k);
    n_checks++; if (d !== 32'hFFFFE000) begin n_fail++; $display("FAIL dn2_word0 got=%h exp=ffffe000", d); end
    bus_read2(BUF2 + 32'd4, d, e, k);
    n_checks++; if (d !== 32'h00001FFF) begin n_fail++; $display("FAIL dn2_word1 got=%h exp=00001fff", d); end
    bus_read2(32'h10, d, e, k);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL dn2_wptr got=%0d exp=1", d); end
    bus_read2(32'h14, d, e, k);
    n_checks++; if (k !== 1'b1 || e !== 1'b1 || d !== 32'd0) begin
      n_fail++; $display("FAIL dn2_unmapped got ack=%b err=%b rdata=%h exp 1/1/0", k, e, d);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_post0();
    test_abort();
    test_bus_err();
    test_dn2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
